pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Detects load-use hazards, flushes wrong-path instructions on a taken branch/jump resolved in EX, and
//  freezes the pipe while data memory is not ready. A wait timer raises a sticky error on a memory hang.
// PARAMETERS
//  MEM_TIMEOUT  16  max consecutive dmem wait cycles before the ERROR state (>=1)
//  CNT_W        32  width of the stall-cycle performance counter
// PORTS
//  CLK            in   1      pipeline clock
//  RESET          in   1      asynchronous, active-high reset
//  id_rs1         in   5      rs1 index of the instruction in ID
//  id_rs2         in   5      rs2 index of the instruction in ID
//  id_uses_rs1    in   1      ID instruction reads rs1
//  id_uses_rs2    in   1      ID instruction reads rs2
//  ex_mem_read    in   1      instruction in EX (ID/EX output) is a load
//  ex_rd          in   5      destination register of the EX instruction
//  ex_redirect    in   1      taken branch/jump resolved in EX this cycle
//  mem_req        in   1      EX/MEM holds a load/store accessing dmem
//  dmem_ready     in   1      dmem completes the access this cycle
//  pc_stall       out  1      hold PC
//  if_id_stall    out  1      hold IF/ID
//  if_id_flush    out  1      load NOP into IF/ID
//  id_ex_stall    out  1      hold ID/EX
//  id_ex_flush    out  1      load bubble (all control 0) into ID/EX
//  ex_mem_stall   out  1      hold EX/MEM
//  mem_wb_flush   out  1      load bubble (WB_control=0) into MEM/WB
//  mem_timeout    out  1      sticky: dmem hang detected
//  stall_cycles   out  CNT_W  saturating count of cycles with pc_stall=1
// BEHAVIOUR
//  - RESET: state=RUN, wait_cnt=0, stall_cycles=0, mem_timeout=0; all stall/flush outputs 0.
//  - States: RUN, MEM_WAIT, ERROR (encoded in package). Outputs combinational from state+inputs.
//  - mem_busy = mem_req & ~dmem_ready. Priority: ERROR > mem_busy > ex_redirect > load-use.
//  - mem_busy (RUN or MEM_WAIT): pc/if_id/id_ex/ex_mem stall=1, mem_wb_flush=1, no other flush.
//    RUN->MEM_WAIT on mem_busy; wait_cnt counts busy cycles (1 on entry cycle).
//    MEM_WAIT->RUN when dmem_ready (that cycle: no memory stall, EX/MEM advances, wait_cnt=0).
//    MEM_WAIT->ERROR when mem_busy and wait_cnt==MEM_TIMEOUT; mem_timeout=1 from next cycle.
//  - ERROR: all four stall outputs=1, mem_wb_flush=1, held until RESET; dmem_ready ignored.
//  - ex_redirect (no mem_busy): if_id_flush=1, id_ex_flush=1, no stalls; PC takes target (not here).
//    Redirect held during a memory stall is acted on the first non-busy cycle (ID/EX is frozen).
//  - load_use = ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
//    load_use (no mem_busy, no redirect): pc_stall=1, if_id_stall=1, id_ex_flush=1; exactly 1 bubble
//    because the load leaves EX next cycle. Redirect masks load_use (ID instruction is wrong-path).
//  - x0 never creates a hazard. stall_cycles += 1 each cycle pc_stall=1; saturates at all-ones.
//  - Async RESET mid-MEM_WAIT or in ERROR returns to RUN immediately; outputs drop same cycle.
//  - Stall and flush of the same register never both asserted.
// STRUCTURE
//  - riscv_pkg: ctrl_state_t {RUN, MEM_WAIT, ERROR}, REG_X0 constant, WB_control bit positions
//    (RegWrite=3, MemtoReg=2, RegSrc=1:0) shared with the pipeline registers.
//  - Sub-module hazard_detect: combinational load_use comparator; FSM, wait timer, counter stay here.
// TESTING
//  1 load x5 in EX, ID add x6,x5,x7 (uses rs1) -> one cycle pc_stall=if_id_stall=id_ex_flush=1, then 0.
//  2 load x0 in EX, ID reads x0; then ID uses_rs2=0 with rs2==ex_rd -> no stall either case.
//  3 ex_redirect=1 with load_use true -> if_id_flush=id_ex_flush=1, pc_stall=0, stall_cycles unchanged.
//  4 mem_req=1, dmem_ready low 3 cycles then high -> 3 cycles of all stalls+mem_wb_flush, return to RUN,
//    stall_cycles=3; redirect held throughout fires flush on cycle 4.
//  5 dmem_ready stuck low, MEM_TIMEOUT=4 -> ERROR after 5th busy cycle, mem_timeout=1 sticky; RESET
//    pulse mid-ERROR -> all outputs 0 asynchronously, state RUN.
//  6 Force stall_cycles near max (CNT_W=4, 20 stall cycles) -> holds 4'hF, no wrap.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared pipeline-control types and constants for the hazard sequencer and pipeline registers.
package riscv_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } ctrl_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    // WB_control field layout inside MEM/WB; a bubble clears the whole field.
    localparam int WB_REG_WRITE  = 3;
    localparam int WB_MEM_TO_REG = 2;
    localparam int WB_REG_SRC_HI = 1;
    localparam int WB_REG_SRC_LO = 0;
    localparam int WB_W          = 4;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: the ID instruction reads the register a load in EX is about to write.
module hazard_detect
    import riscv_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    // x0 is hardwired to zero, so a load targeting it never produces a dependency.
    assign load_use = ex_mem_read && (ex_rd != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: load-use bubbles, redirect flushes,
// dmem wait freezing with a hang timer, and a saturating stall-cycle counter.
//
//  state    | meaning
//  ---------+---------------------------------------------------------------
//  RUN      | normal flow; hazards handled combinationally
//  MEM_WAIT | dmem access outstanding, pipe frozen, wait_cnt counting
//  ERROR    | dmem hang detected; pipe frozen until RESET
module pipeline_hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_wb_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    ctrl_state_t       state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_busy;
    logic              load_use;

    assign mem_busy = mem_req && !dmem_ready;

    hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .load_use    (load_use)
    );

    // Gated by RESET so the pipe is released the instant reset asserts, whatever the inputs.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_flush = 1'b0;
        if (!RESET) begin
            if ((state == ERROR) || mem_busy) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_stall  = 1'b1;
                ex_mem_stall = 1'b1;
                mem_wb_flush = 1'b1;
            end else if (ex_redirect) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state        <= RUN;
            wait_cnt     <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (pc_stall && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + CNT_W'(1);

            case (state)
                RUN: begin
                    if (mem_busy) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!mem_busy) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                        state       <= ERROR;
                        mem_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table for single-cycle hazard decode,
// hand-written sequences for memory wait, timeout, async reset and counter saturation.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned T_OUT = 4;
    localparam int unsigned CW    = 4;

    // output vector order: {pc, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush}
    localparam logic [6:0] O_NONE = 7'b0000000;
    localparam logic [6:0] O_LU   = 7'b1100100;
    localparam logic [6:0] O_RDR  = 7'b0010100;
    localparam logic [6:0] O_MEM  = 7'b1101011;

    logic          CLK;
    logic          RESET;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect, mem_req, dmem_ready;
    logic          pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic          ex_mem_stall, mem_wb_flush, mem_timeout;
    logic [CW-1:0] stall_cycles;
    logic [6:0]    outs;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_sc = 0;

    assign outs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush};

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(T_OUT), .CNT_W(CW)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .ex_redirect  (ex_redirect),
        .mem_req      (mem_req),
        .dmem_ready   (dmem_ready),
        .pc_stall     (pc_stall),
        .if_id_stall  (if_id_stall),
        .if_id_flush  (if_id_flush),
        .id_ex_stall  (id_ex_stall),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_stall (ex_mem_stall),
        .mem_wb_flush (mem_wb_flush),
        .mem_timeout  (mem_timeout),
        .stall_cycles (stall_cycles)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mr;
        logic [4:0] rd;
        logic       redir;
        logic       req;
        logic       rdy;
        logic [6:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mkv(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                                 input logic u2, input logic mr, input logic [4:0] rd,
                                 input logic redir, input logic req, input logic rdy,
                                 input logic [6:0] exp, input string name);
        vec_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.mr = mr; v.rd = rd;
        v.redir = redir; v.req = req; v.rdy = rdy; v.exp = exp; v.name = name;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        id_rs1 = v.rs1; id_rs2 = v.rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
        ex_mem_read = v.mr; ex_rd = v.rd; ex_redirect = v.redir;
        mem_req = v.req; dmem_ready = v.rdy;
    endtask

    task automatic clear_inputs();
        drive(mkv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, O_NONE, "idle"));
    endtask

    // Inputs are already applied just after the rising edge; sample at the falling edge.
    task automatic run_cycle(input logic [6:0] exp, input logic exp_to, input string name);
        @(negedge CLK);
        chk({name, ".outs"}, 32'(outs), 32'(exp));
        chk({name, ".mem_timeout"}, 32'(mem_timeout), 32'(exp_to));
        chk({name, ".stall_cycles"}, 32'(stall_cycles), 32'(exp_sc));
        chk({name, ".if_id_excl"}, 32'(if_id_stall & if_id_flush), 32'd0);
        chk({name, ".id_ex_excl"}, 32'(id_ex_stall & id_ex_flush), 32'd0);
        if (exp[6] && exp_sc < (1 << CW) - 1) exp_sc++;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        RESET = 1'b1;
        exp_sc = 0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    initial begin
        vecs[0] = mkv(5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, O_NONE, "idle");
        vecs[1] = mkv(5'd5,  5'd7,  1'b1, 1'b1, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, O_LU,   "lu_rs1");
        vecs[2] = mkv(5'd5,  5'd7,  1'b1, 1'b1, 1'b0, 5'd5,  1'b0, 1'b0, 1'b0, O_NONE, "load_left");
        vecs[3] = mkv(5'd3,  5'd5,  1'b1, 1'b1, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, O_LU,   "lu_rs2");
        vecs[4] = mkv(5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b0, O_NONE, "x0_load");
        vecs[5] = mkv(5'd6,  5'd5,  1'b1, 1'b0, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, O_NONE, "rs2_unused");
        vecs[6] = mkv(5'd5,  5'd7,  1'b1, 1'b1, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, O_RDR,  "redir_masks_lu");
        vecs[7] = mkv(5'd1,  5'd2,  1'b0, 1'b0, 1'b0, 5'd9,  1'b1, 1'b0, 1'b0, O_RDR,  "redir_only");
        vecs[8] = mkv(5'd31, 5'd31, 1'b1, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, O_LU,   "lu_x31");
        vecs[9] = mkv(5'd8,  5'd4,  1'b1, 1'b0, 1'b1, 5'd8,  1'b0, 1'b1, 1'b1, O_LU,   "lu_mem_ready");

        RESET = 1'b0;
        clear_inputs();
        #2;
        RESET = 1'b1;
        #1;
        chk("reset.outs", 32'(outs), 32'(O_NONE));
        chk("reset.mem_timeout", 32'(mem_timeout), 32'd0);
        chk("reset.stall_cycles", 32'(stall_cycles), 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        exp_sc = 0;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i]);
            run_cycle(vecs[i].exp, 1'b0, vecs[i].name);
        end
        clear_inputs();
        run_cycle(O_NONE, 1'b0, "table_end");

        // dmem wait of 3 cycles with a redirect held; redirect fires once memory completes
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(mkv(5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, O_MEM, "memwait"));
            run_cycle(O_MEM, 1'b0, "memwait");
        end
        dmem_ready = 1'b1;
        run_cycle(O_RDR, 1'b0, "memwait_release");
        clear_inputs();
        run_cycle(O_NONE, 1'b0, "memwait_run");
        chk("memwait.total_stalls", 32'(exp_sc), 32'd3);
        // a fresh 4-cycle wait must not time out: wait counter restarted
        mem_req = 1'b1;
        for (int i = 0; i < 4; i++) run_cycle(O_MEM, 1'b0, "memwait2");
        dmem_ready = 1'b1;
        run_cycle(O_NONE, 1'b0, "memwait2_release");

        // dmem hang: ERROR after 5th busy cycle, sticky, dmem_ready ignored
        do_reset();
        mem_req = 1'b1;
        for (int i = 0; i < 5; i++) run_cycle(O_MEM, 1'b0, "hang_busy");
        run_cycle(O_MEM, 1'b1, "hang_err");
        dmem_ready = 1'b1;
        run_cycle(O_MEM, 1'b1, "err_ready_ignored");
        mem_req = 1'b0;
        dmem_ready = 1'b0;
        run_cycle(O_MEM, 1'b1, "err_idle");
        #3;
        RESET = 1'b1;
        #1;
        chk("async_rst.outs", 32'(outs), 32'(O_NONE));
        chk("async_rst.mem_timeout", 32'(mem_timeout), 32'd0);
        chk("async_rst.stall_cycles", 32'(stall_cycles), 32'd0);
        exp_sc = 0;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        clear_inputs();
        run_cycle(O_NONE, 1'b0, "after_rst_run");

        // counter saturation: 20 load-use stall cycles on a 4-bit counter
        do_reset();
        drive(vecs[1]);
        for (int i = 0; i < 20; i++) run_cycle(O_LU, 1'b0, "sat");
        clear_inputs();
        run_cycle(O_NONE, 1'b0, "sat_end");
        chk("sat.final", 32'(stall_cycles), 32'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
